wb_apa102_chain: RTL and testbench
==================================

// Module: wb_apa102_chain
// PURPOSE
//  Wishbone-classic slave driving an APA102/DotStar chain of NUM_LEDS pixels over a 2-wire SCK/SDI link.
//  Next generation of the fixed 8-pixel Blinkt bar driver, which it replaces in the serial-to-Wishbone bridge fabric.
//  Adds parametrised chain length, programmable bit rate, one-shot/auto-refresh modes, status and error response.
// PARAMETERS
//  NUM_LEDS    8   pixels in chain, 1..256
//  CLK_DIV     4   i_clk cycles per SCK half-period, >=1
//  ADDR_WIDTH  32  Wishbone address width; data width fixed at 32, SEL width 4
// PORTS
//  i_clk       in   1   system clock, all logic rising-edge
//  i_rst       in   1   asynchronous, active-high reset
//  wb_adr_i    in   ADDR_WIDTH  byte address
//  wb_dat_i    in   32  write data
//  wb_dat_o    out  32  read data, valid while wb_ack_o=1
//  wb_we_i     in   1   write enable
//  wb_sel_i    in   4   byte lane enables (writes only)
//  wb_stb_i    in   1   strobe
//  wb_cyc_i    in   1   cycle
//  wb_ack_o    out  1   acknowledge
//  wb_err_o    out  1   error (unmapped address)
//  wb_rty_o    out  1   retry, tied 0
//  o_led_clk   out  1   APA102 SCK, idles low
//  o_led_data  out  1   APA102 SDI
// BEHAVIOUR
//  Reset (async, i_rst=1): all outputs 0, all registers and pixel RAM 0, FSM IDLE, pending=0.
//  Bus: request = stb&cyc&~ack&~err; ack (or err) registered, exactly 1 cycle, asserted the edge after request is sampled.
//   Master holding stb after ack gets a new ack every 2nd cycle. Write side effects take place on the ack/err edge.
//  Map (index = wb_adr_i[ADDR_WIDTH-1:2]): 0x000 CTRL, 0x004 STATUS, 0x100+4n PIXEL n (n<NUM_LEDS); other -> err, no write.
//  CTRL: [0] GO write-1 self-clearing, reads 0; [1] AUTO r/w; [8] BUSY read-only.
//  STATUS: [15:0] frames completed, wraps 0xFFFF->0; write has no effect, acked.
//  PIXEL: [28:24] brightness, [23:16] blue, [15:8] green, [7:0] red; [31:29] stored, on wire forced to 3'b111.
//  All writes honour wb_sel_i per byte; read returns full stored word.
//  Frame = START (32 zero bits) + NUM_LEDS pixel words + END (END_WORDS=1+NUM_LEDS/64 words of all ones), MSB first.
//  SCK: SDI changes while SCK low; rising edge CLK_DIV cycles later, falling CLK_DIV after that -> 2*CLK_DIV clocks/bit.
//  FSM: IDLE -> START on GO (or AUTO=1); START -> LEDS after 32 bits; LEDS -> END after last pixel; END -> IDLE or START.
//   On leaving END: frames++; if pending or AUTO then START next cycle (pending cleared), else IDLE.
//  BUSY=1 in START/LEDS/END; rises on the GO ack edge. GO while BUSY sets pending (multiple GOs coalesce into one).
//  Pixel word captured into shift register at word start; a write to a pixel being shifted applies next frame.
//  AUTO cleared mid-frame: current frame completes, then IDLE. SCK low and SDI 0 in IDLE.
//  Reset mid-frame: SCK/SDI drop to 0 immediately; no partial frame resumes.
// STRUCTURE
//  apa102_pkg: state enum (IDLE/START/LEDS/END), register offsets, CTRL bit positions, pixel field ranges,
//   function end_words(n). Sub-module apa102_shifter: CLK_DIV prescaler + 32-bit serializer.
//   Interface: load/word_in/ready; top holds regfile, pixel RAM, FSM, bus logic.
// TESTING
//  1 write PIXEL0=0x1F102030, CTRL=1 (NUM_LEDS=8) -> 32 zeros, 0xFF102030, 7x 0xE0000000, 32 ones; STATUS=1.
//  2 read 0x080 -> err 1 cycle, ack 0, dat ignored; write 0x120 (n=8) -> err, RAM unchanged.
//  3 PIXEL1=0, write 0xAABBCCDD sel=4'b0101 -> read 0x00BB00DD.
//  4 GO, then GO twice during LEDS -> exactly 2 frames, back-to-back, STATUS=2, BUSY 0 after.
//  5 AUTO=1 for ~3.5 frames then AUTO=0 -> frame 4 completes, STATUS=4, IDLE with SCK low.
//  6 i_rst pulse mid-LEDS -> SCK/SDI 0 same cycle, CTRL/STATUS/RAM read 0, next GO yields clean frame.

Source files
------------

// File: rtl/apa102_pkg.sv
// Shared definitions for the Wishbone APA102/DotStar chain driver.
//   state_t      : frame sequencer states (IDLE/START/LEDS/END)
//   *_IDX        : register word indices (byte address >> 2)
//   CTRL_*_BIT   : CTRL register bit positions
//   PIX_*        : pixel word layout (brightness/blue/green/red, wire header)
//   end_words()  : number of all-ones END words for an n-pixel chain
//   pixel_wire() : stored pixel word -> word as sent on the wire
package apa102_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_LEDS  = 2'd2,
    ST_END   = 2'd3
  } state_t;

  localparam int REG_CTRL_IDX   = 0;
  localparam int REG_STATUS_IDX = 1;
  localparam int PIXEL_BASE_IDX = 'h40;

  localparam int CTRL_GO_BIT   = 0;
  localparam int CTRL_AUTO_BIT = 1;
  localparam int CTRL_BUSY_BIT = 8;

  localparam int PIX_BRI_MSB = 28;
  localparam int PIX_BRI_LSB = 24;
  localparam int PIX_HDR_LSB = 29;
  localparam logic [2:0] PIX_HDR = 3'b111;

  // Enough trailing clock edges for every pixel to forward its data.
  function automatic int end_words(input int n);
    return 1 + n / 64;
  endfunction

  // Top three bits of a pixel word are always 1 on the wire.
  function automatic logic [31:0] pixel_wire(input logic [31:0] w);
    return w | (32'(PIX_HDR) << PIX_HDR_LSB);
  endfunction

endpackage

// File: rtl/apa102_shifter.sv
// 32-bit MSB-first serializer with CLK_DIV prescaler for the APA102 link.
//   i_clk, i_rst : system clock, async active-high reset
//   load_i       : capture word_i and start shifting (taken when ready_o=1)
//   word_i       : 32-bit word to send
//   ready_o      : idle, or in the last cycle of bit 0 of the current word
//   sck_o        : serial clock, low for CLK_DIV cycles then high for CLK_DIV
//   sdi_o        : serial data, changes only while sck_o is low
module apa102_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        load_i,
  input  logic [31:0] word_i,
  output logic        ready_o,
  output logic        sck_o,
  output logic        sdi_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_q;
  logic          half_q;
  logic          busy_q;
  logic [4:0]    bit_q;
  logic [31:0]   sr_q;
  logic          div_last;
  logic          bit_end;

  assign div_last = (div_q == CW'(CLK_DIV - 1));
  assign bit_end  = busy_q & half_q & div_last;
  // Ready on the falling-edge cycle of the last bit so words stream gap-free.
  assign ready_o  = ~busy_q | (bit_end & (bit_q == 5'd31));
  assign sck_o    = half_q;
  assign sdi_o    = busy_q & sr_q[31];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_q  <= '0;
      half_q <= 1'b0;
      busy_q <= 1'b0;
      bit_q  <= '0;
      sr_q   <= '0;
    end else if (ready_o && load_i) begin
      sr_q   <= word_i;
      busy_q <= 1'b1;
      div_q  <= '0;
      half_q <= 1'b0;
      bit_q  <= '0;
    end else if (ready_o) begin
      busy_q <= 1'b0;
      half_q <= 1'b0;
      div_q  <= '0;
    end else if (div_last) begin
      div_q  <= '0;
      half_q <= ~half_q;
      if (half_q) begin
        sr_q  <= {sr_q[30:0], 1'b0};
        bit_q <= bit_q + 5'd1;
      end
    end else begin
      div_q <= div_q + CW'(1);
    end
  end

endmodule

// File: rtl/wb_apa102_chain.sv
// Wishbone-classic slave driving an APA102/DotStar chain of NUM_LEDS pixels.
//   i_clk, i_rst   : system clock, async active-high reset
//   wb_*_i/_o      : Wishbone classic slave (32-bit data, byte address)
//                    0x000 CTRL (GO/AUTO/BUSY), 0x004 STATUS (frame count),
//                    0x100+4n PIXEL n; anything else answers with err
//   o_led_clk      : APA102 SCK, low when idle
//   o_led_data     : APA102 SDI
module wb_apa102_chain
  import apa102_pkg::*;
#(
  parameter int NUM_LEDS   = 8,
  parameter int CLK_DIV    = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  output logic                  o_led_clk,
  output logic                  o_led_data
);

  localparam int END_W = end_words(NUM_LEDS);
  localparam int PW    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int WA    = ADDR_WIDTH - 2;

  state_t        state_q, state_d;
  logic [8:0]    idx_q, idx_d;
  logic [8:0]    seg_len;
  logic          pending_q, pending_d;
  logic [15:0]   frames_q, frames_d;
  logic          auto_q;
  logic          ack_q, err_q;
  logic [31:0]   dat_q;
  logic [31:0]   ram_q [NUM_LEDS];

  logic [WA-1:0] word_adr, pix_off;
  logic          req, wr, ctrl_hit, stat_hit, pix_hit, hit, go_pulse, busy;
  logic [PW-1:0] pix_sel;
  logic [31:0]   rd_data;
  logic          sh_ready, sh_load;
  logic [31:0]   sh_word;
  logic          unused_adr;

  function automatic logic [31:0] wire_word(input state_t s, input logic [31:0] pix);
    case (s)
      ST_LEDS: wire_word = pixel_wire(pix);
      ST_END:  wire_word = '1;
      default: wire_word = '0;
    endcase
  endfunction

  assign unused_adr = ^wb_adr_i[1:0];
  assign word_adr   = wb_adr_i[ADDR_WIDTH-1:2];
  assign pix_off    = word_adr - WA'(PIXEL_BASE_IDX);
  assign pix_sel    = pix_off[PW-1:0];
  assign req        = wb_stb_i & wb_cyc_i & ~ack_q & ~err_q;
  assign wr         = req & wb_we_i;
  assign ctrl_hit   = (word_adr == WA'(REG_CTRL_IDX));
  assign stat_hit   = (word_adr == WA'(REG_STATUS_IDX));
  assign pix_hit    = (word_adr >= WA'(PIXEL_BASE_IDX)) && (pix_off < WA'(NUM_LEDS));
  assign hit        = ctrl_hit | stat_hit | pix_hit;
  assign go_pulse   = wr & ctrl_hit & wb_sel_i[0] & wb_dat_i[CTRL_GO_BIT];
  assign busy       = (state_q != ST_IDLE);

  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_dat_o   = dat_q;
  assign wb_rty_o   = 1'b0;

  always_comb begin
    rd_data = '0;
    if (ctrl_hit) begin
      rd_data[CTRL_AUTO_BIT] = auto_q;
      rd_data[CTRL_BUSY_BIT] = busy;
    end else if (stat_hit) begin
      rd_data[15:0] = frames_q;
    end else if (pix_hit) begin
      rd_data = ram_q[pix_sel];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      dat_q  <= '0;
      auto_q <= 1'b0;
    end else begin
      ack_q <= req & hit;
      err_q <= req & ~hit;
      dat_q <= (req & hit & ~wb_we_i) ? rd_data : '0;
      if (wr && ctrl_hit && wb_sel_i[0]) auto_q <= wb_dat_i[CTRL_AUTO_BIT];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_LEDS; i++) ram_q[i] <= '0;
    end else if (wr && pix_hit) begin
      for (int b = 0; b < 4; b++)
        if (wb_sel_i[b]) ram_q[pix_sel][8*b +: 8] <= wb_dat_i[8*b +: 8];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      frames_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      frames_q  <= frames_d;
    end
  end

  // idx_q counts words already handed to the shifter in the current segment;
  // once a segment is exhausted, the next segment's first word is loaded on
  // the same edge so the stream has no gaps.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    frames_d  = frames_q;
    sh_load   = 1'b0;
    sh_word   = '0;
    case (state_q)
      ST_LEDS: seg_len = 9'(NUM_LEDS);
      ST_END:  seg_len = 9'(END_W);
      default: seg_len = 9'd1;
    endcase
    if (go_pulse && busy) pending_d = 1'b1;
    if (state_q == ST_IDLE) begin
      if (go_pulse || auto_q) begin
        state_d = ST_START;
        idx_d   = '0;
      end
    end else if (sh_ready) begin
      if (idx_q < seg_len) begin
        sh_load = 1'b1;
        idx_d   = idx_q + 9'd1;
        sh_word = wire_word(state_q, ram_q[idx_q[PW-1:0]]);
      end else begin
        sh_load = 1'b1;
        idx_d   = 9'd1;
        case (state_q)
          ST_START: begin
            state_d = ST_LEDS;
            sh_word = wire_word(ST_LEDS, ram_q[0]);
          end
          ST_LEDS: begin
            state_d = ST_END;
            sh_word = '1;
          end
          default: begin
            frames_d = frames_q + 16'd1;
            if (pending_q || go_pulse || auto_q) begin
              state_d   = ST_START;
              pending_d = 1'b0;
              sh_word   = '0;
            end else begin
              state_d = ST_IDLE;
              idx_d   = '0;
              sh_load = 1'b0;
            end
          end
        endcase
      end
    end
  end

  apa102_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .load_i (sh_load),
    .word_i (sh_word),
    .ready_o(sh_ready),
    .sck_o  (o_led_clk),
    .sdi_o  (o_led_data)
  );

endmodule

// File: tb/tb_wb_apa102_chain.sv
module tb_wb_apa102_chain;

  localparam int NUM_LEDS    = 8;
  localparam int CLK_DIV     = 2;
  localparam int AW          = 32;
  localparam int END_W       = 1 + NUM_LEDS / 64;
  localparam int FRAME_WORDS = 1 + NUM_LEDS + END_W;
  localparam int FRAME_BITS  = 32 * FRAME_WORDS;
  localparam int FRAME_CYC   = FRAME_BITS * 2 * CLK_DIV;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] adr = '0;
  logic [31:0]   dat_w = '0;
  logic [31:0]   dat_r;
  logic          we = 1'b0;
  logic [3:0]    sel = '0;
  logic          stb = 1'b0;
  logic          cyc = 1'b0;
  logic          ack, err, rty, led_clk, led_data;

  int            vectors = 0;
  int            miscompares = 0;
  int            exp_frames = 0;
  int            cyc_cnt = 0;
  logic [31:0]   mram [NUM_LEDS];
  bit            bits [$];
  int            rise_t [$];

  always #5 clk = ~clk;

  wb_apa102_chain #(
    .NUM_LEDS  (NUM_LEDS),
    .CLK_DIV   (CLK_DIV),
    .ADDR_WIDTH(AW)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .wb_adr_i  (adr),
    .wb_dat_i  (dat_w),
    .wb_dat_o  (dat_r),
    .wb_we_i   (we),
    .wb_sel_i  (sel),
    .wb_stb_i  (stb),
    .wb_cyc_i  (cyc),
    .wb_ack_o  (ack),
    .wb_err_o  (err),
    .wb_rty_o  (rty),
    .o_led_clk (led_clk),
    .o_led_data(led_data)
  );

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // The pixel sees SDI on each SCK rising edge.
  always @(posedge led_clk) begin
    bits.push_back(led_data);
    rise_t.push_back(cyc_cnt);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = d[8*b +: 8];
    return o;
  endfunction

  // Word w of an ideal frame built from the model pixel memory.
  function automatic logic [31:0] exp_word(input int w);
    if (w == 0) return 32'h0;
    if (w <= NUM_LEDS) return {3'b111, mram[w-1][28:0]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic wb_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic w, output logic [31:0] rd, output logic ak,
                         output logic er);
    @(negedge clk);
    adr = a; dat_w = d; sel = s; we = w; stb = 1'b1; cyc = 1'b1;
    ak = 1'b0; er = 1'b0; rd = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack || err) begin
        ak = ack; er = err; rd = dat_r;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input bit exp_err, input string tag);
    logic [31:0] rd;
    logic        ak, er;
    wb_xfer(a, d, s, 1'b1, rd, ak, er);
    check({tag, "_resp"}, 32'({er, ak}), exp_err ? 32'd2 : 32'd1);
  endtask

  task automatic wb_rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] rd;
    logic        ak, er;
    wb_xfer(a, 32'h0, 4'h0, 1'b0, rd, ak, er);
    check({tag, "_resp"}, 32'({er, ak}), 32'd1);
    check({tag, "_data"}, rd, exp);
  endtask

  task automatic wait_bits(input int n);
    int c = 0;
    while (bits.size() < n && c < 8 * FRAME_CYC) begin
      @(posedge clk);
      c++;
    end
    check("wait_bits", 32'(bits.size() >= n), 32'd1);
  endtask

  task automatic check_frames(input int nf, input string tag);
    logic [31:0] word;
    wait_bits(nf * FRAME_BITS);
    if (bits.size() < nf * FRAME_BITS) return;
    for (int f = 0; f < nf; f++) begin
      for (int w = 0; w < FRAME_WORDS; w++) begin
        word = '0;
        for (int b = 0; b < 32; b++) begin
          word = {word[30:0], bits.pop_front()};
          void'(rise_t.pop_front());
        end
        check($sformatf("%s_f%0d_w%0d", tag, f, w), word, exp_word(w));
      end
    end
  endtask

  task automatic settle();
    repeat (8 * CLK_DIV) @(posedge clk);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] rd;
    logic [3:0]  s;
    logic        ak, er;
    int          n;

    for (int i = 0; i < NUM_LEDS; i++) mram[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sck", 32'(led_clk), 32'd0);
    check("rst_sdi", 32'(led_data), 32'd0);
    check("rst_ackerr", 32'({err, ack}), 32'd0);
    check("rst_dat", dat_r, 32'd0);
    check("rty", 32'(rty), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wb_rd(32'h000, 32'h0, "rst_ctrl");
    wb_rd(32'h004, 32'h0, "rst_status");
    wb_rd(32'h100, 32'h0, "rst_pix0");

    // One-shot frame with a single lit pixel.
    wb_wr(32'h100, 32'h1F10_2030, 4'hF, 1'b0, "t1_pix0");
    mram[0] = 32'h1F10_2030;
    wb_wr(32'h000, 32'h1, 4'hF, 1'b0, "t1_go");
    wb_rd(32'h000, 32'h100, "t1_busy");
    wait_bits(2);
    if (rise_t.size() >= 2) check("t1_bitper", 32'(rise_t[1] - rise_t[0]), 32'(2 * CLK_DIV));
    check_frames(1, "t1");
    exp_frames++;
    settle();
    wb_rd(32'h004, 32'(exp_frames), "t1_status");
    wb_rd(32'h000, 32'h0, "t1_idle");

    // Unmapped accesses answer with a one-cycle err and leave the RAM alone.
    wb_xfer(32'h080, 32'h0, 4'h0, 1'b0, rd, ak, er);
    check("t2_rd_resp", 32'({er, ak}), 32'd2);
    @(posedge clk); #1;
    check("t2_err_1cyc", 32'({err, ack}), 32'd0);
    wb_wr(32'h120, 32'hDEAD_BEEF, 4'hF, 1'b1, "t2_wr_oob");
    wb_wr(32'h004, 32'h0000_FFFF, 4'hF, 1'b0, "t2_wr_status");
    wb_rd(32'h004, 32'(exp_frames), "t2_status_ro");
    for (int i = 0; i < NUM_LEDS; i++)
      wb_rd(32'h100 + 32'(4 * i), mram[i], $sformatf("t2_pix%0d", i));

    // Byte-lane writes.
    wb_wr(32'h104, 32'h0, 4'hF, 1'b0, "t3_clr");
    mram[1] = 32'h0;
    wb_wr(32'h104, 32'hAABB_CCDD, 4'b0101, 1'b0, "t3_sel");
    mram[1] = merge(mram[1], 32'hAABB_CCDD, 4'b0101);
    wb_rd(32'h104, mram[1], "t3_rd");
    for (int i = 2; i < NUM_LEDS; i++) begin
      d = $urandom;
      s = 4'($urandom_range(1, 15));
      wb_wr(32'h100 + 32'(4 * i), d, s, 1'b0, $sformatf("t3_rnd%0d", i));
      mram[i] = merge(mram[i], d, s);
    end

    // GO plus two more GOs mid-frame coalesce into one extra frame.
    wb_wr(32'h000, 32'h1, 4'hF, 1'b0, "t4_go");
    wait_bits(32 + 40);
    wb_wr(32'h000, 32'h1, 4'hF, 1'b0, "t4_go2");
    wb_wr(32'h000, 32'h1, 4'hF, 1'b0, "t4_go3");
    wait_bits(2 * FRAME_BITS);
    if (rise_t.size() > FRAME_BITS)
      check("t4_b2b", 32'((rise_t[FRAME_BITS] - rise_t[FRAME_BITS-1]) <= 3 * CLK_DIV), 32'd1);
    check_frames(2, "t4");
    exp_frames += 2;
    repeat (FRAME_CYC) @(posedge clk);
    check("t4_no_extra", 32'(bits.size()), 32'd0);
    wb_rd(32'h004, 32'(exp_frames), "t4_status");
    wb_rd(32'h000, 32'h0, "t4_idle");

    // Auto refresh, switched off part-way through the fourth frame.
    for (int i = 0; i < NUM_LEDS; i++) begin
      d = $urandom;
      wb_wr(32'h100 + 32'(4 * i), d, 4'hF, 1'b0, $sformatf("t5_pix%0d", i));
      mram[i] = d;
    end
    wb_wr(32'h000, 32'h2, 4'hF, 1'b0, "t5_auto_on");
    wb_rd(32'h000, 32'h102, "t5_ctrl");
    wait_bits(3 * FRAME_BITS + FRAME_BITS / 2);
    wb_wr(32'h000, 32'h0, 4'hF, 1'b0, "t5_auto_off");
    check_frames(4, "t5");
    exp_frames += 4;
    repeat (FRAME_CYC) @(posedge clk);
    check("t5_no_extra", 32'(bits.size()), 32'd0);
    wb_rd(32'h004, 32'(exp_frames), "t5_status");
    wb_rd(32'h000, 32'h0, "t5_idle");
    #1;
    check("t5_sck_low", 32'(led_clk), 32'd0);

    // Asynchronous reset in the middle of the pixel words.
    wb_wr(32'h000, 32'h1, 4'hF, 1'b0, "t6_go");
    wait_bits(32 + 64);
    for (int c = 0; c < 4 * CLK_DIV; c++) begin
      @(posedge clk); #1;
      if (led_clk) break;
    end
    #2 rst = 1'b1;
    #1;
    check("t6_sck_drop", 32'(led_clk), 32'd0);
    check("t6_sdi_drop", 32'(led_data), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bits.delete();
    rise_t.delete();
    for (int i = 0; i < NUM_LEDS; i++) mram[i] = '0;
    exp_frames = 0;
    wb_rd(32'h000, 32'h0, "t6_ctrl");
    wb_rd(32'h004, 32'h0, "t6_status");
    for (int i = 0; i < NUM_LEDS; i++)
      wb_rd(32'h100 + 32'(4 * i), 32'h0, $sformatf("t6_pix%0d", i));
    repeat (FRAME_CYC / 4) @(posedge clk);
    check("t6_no_resume", 32'(bits.size()), 32'd0);
    n = $urandom_range(0, NUM_LEDS - 1);
    d = $urandom;
    wb_wr(32'h100 + 32'(4 * n), d, 4'hF, 1'b0, "t6_pix");
    mram[n] = d;
    wb_wr(32'h000, 32'h1, 4'hF, 1'b0, "t6_go2");
    check_frames(1, "t6");
    exp_frames++;
    settle();
    wb_rd(32'h004, 32'(exp_frames), "t6_status2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
